// File: rtl/uart_dbg_pkg.sv
// Shared types and helpers for the UART debug serializer.
// Frame width helper and default header value.
package uart_dbg_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_HDR,
      S_DATA,
      S_CSUM,
      S_GAP
   } fsm_t;

   localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

   function automatic int frame_w(input int n_bytes);
      return 8 * n_bytes;
   endfunction

endpackage

// File: rtl/frame_fifo.sv
// Small frame FIFO feeding the serializer.
// Pointers carry an extra wrap bit to tell full from empty.
module frame_fifo
   import uart_dbg_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] wdata_i,
   input  logic         push_i,
   input  logic         pop_i,
   output logic [W-1:0] rdata_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wp_q, wp_d;
   logic [AW:0]  rp_q, rp_d;
   logic         do_push;
   logic         do_pop;

   assign empty_o = (wp_q == rp_q);
   assign full_o  = (wp_q[AW] != rp_q[AW]) &&
                    (wp_q[AW-1:0] == rp_q[AW-1:0]);

   // A pop frees the head slot, so a push may land when full.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   assign wp_d    = wp_q + {{AW{1'b0}}, do_push};
   assign rp_d    = rp_q + {{AW{1'b0}}, do_pop};
   assign rdata_o = mem_q[rp_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         wp_q <= wp_d;
         rp_q <= rp_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wp_q[AW-1:0]] <= wdata_i;
      end
   end

endmodule

// File: rtl/frame_uart_serializer.sv
// Buffers wide frames and emits them byte by byte to a UART
// with optional header and mod-256 checksum bytes.
module frame_uart_serializer
   import uart_dbg_pkg::*;
#(
   parameter int         N_BYTES    = 51,
   parameter int         FIFO_DEPTH = 2,
   parameter bit         MSB_FIRST  = 1'b1,
   parameter bit         HDR_EN     = 1'b1,
   parameter logic [7:0] HDR_BYTE   = HDR_BYTE_DEF,
   parameter bit         CSUM_EN    = 1'b1,
   parameter int         GUARD      = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [frame_w(N_BYTES)-1:0]   s_data,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic                          tx_busy,
   output logic [7:0]                    tx_data,
   output logic                          tx_send,
   output logic                          frame_done,
   output logic                          active
);

   localparam int FW = frame_w(N_BYTES);
   localparam int CW = $clog2(N_BYTES) + 1;
   localparam int GW = $clog2(GUARD) + 1;

   fsm_t            state_q;
   fsm_t            last_q;
   logic [FW-1:0]   sh_q;
   logic [CW-1:0]   cnt_q;
   logic [7:0]      csum_q;
   logic [GW-1:0]   gcnt_q;
   logic [7:0]      tx_data_q;
   logic            tx_send_q;
   logic            done_q;

   logic [FW-1:0]   head_frame;
   logic            full;
   logic            empty;
   logic            pop;
   logic [7:0]      head;
   logic [FW-1:0]   sh_d;

   assign pop     = (state_q == S_IDLE) && !empty;
   assign s_ready = !full;
   assign active  = (state_q != S_IDLE) || !empty;

   assign head = MSB_FIRST ? sh_q[FW-1 -: 8] : sh_q[7:0];
   assign sh_d = MSB_FIRST ? (sh_q << 8) : (sh_q >> 8);

   assign tx_data    = tx_data_q;
   assign tx_send    = tx_send_q;
   assign frame_done = done_q;

   frame_fifo #(
      .W     (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wdata_i (s_data),
      .push_i  (s_valid && s_ready),
      .pop_i   (pop),
      .rdata_o (head_frame),
      .full_o  (full),
      .empty_o (empty)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         last_q    <= S_IDLE;
         sh_q      <= '0;
         cnt_q     <= '0;
         csum_q    <= '0;
         gcnt_q    <= '0;
         tx_data_q <= '0;
         tx_send_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         tx_send_q <= 1'b0;
         done_q    <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (!empty) begin
                  sh_q    <= head_frame;
                  csum_q  <= '0;
                  cnt_q   <= CW'(N_BYTES - 1);
                  state_q <= S_LOAD;
               end
            end
            S_LOAD: begin
               state_q <= HDR_EN ? S_HDR : S_DATA;
            end
            S_HDR: begin
               if (!tx_busy) begin
                  tx_data_q <= HDR_BYTE;
                  tx_send_q <= 1'b1;
                  last_q    <= S_HDR;
                  gcnt_q    <= '0;
                  state_q   <= S_GAP;
               end
            end
            S_DATA: begin
               if (!tx_busy) begin
                  tx_data_q <= head;
                  tx_send_q <= 1'b1;
                  done_q    <= !CSUM_EN && (cnt_q == '0);
                  sh_q      <= sh_d;
                  csum_q    <= csum_q + head;
                  last_q    <= S_DATA;
                  gcnt_q    <= '0;
                  state_q   <= S_GAP;
               end
            end
            S_CSUM: begin
               if (!tx_busy) begin
                  tx_data_q <= csum_q;
                  tx_send_q <= 1'b1;
                  done_q    <= 1'b1;
                  last_q    <= S_CSUM;
                  gcnt_q    <= '0;
                  state_q   <= S_GAP;
               end
            end
            S_GAP: begin
               // tx_busy is ignored here: the UART needs time to raise it.
               if (gcnt_q == GW'(GUARD - 1)) begin
                  unique case (last_q)
                     S_HDR: state_q <= S_DATA;
                     S_DATA: begin
                        if (cnt_q != '0) begin
                           cnt_q   <= cnt_q - 1'b1;
                           state_q <= S_DATA;
                        end else begin
                           state_q <= CSUM_EN ? S_CSUM : S_IDLE;
                        end
                     end
                     default: state_q <= S_IDLE;
                  endcase
               end else begin
                  gcnt_q <= gcnt_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_uart_serializer.sv
// Directed bench: two serializer configurations behind a busy UART model.
// Byte streams, handshakes, stalls and reset abort are checked.
module tb_frame_uart_serializer;

   localparam int NB = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] sdata [2];
   logic        svalid [2];
   logic        sready [2];
   logic        busy [2];
   logic        txs [2];
   logic        fd [2];
   logic        act [2];
   logic [7:0]  txd [2];
   logic        hold [2];
   int          bc [2] = '{0, 0};

   int total = 0;
   int bad = 0;
   int cyc = 0;

   logic [7:0]  cap [2][64];
   logic        capd [2][64];
   int          nstr [2] = '{0, 0};
   int          last [2] = '{-100, -100};

   typedef struct {
      int          k;
      logic [31:0] frame;
      int          n;
      logic [47:0] exp;
   } vec_t;

   vec_t vec [7];

   always #5 clk = ~clk;

   frame_uart_serializer #(
      .N_BYTES(NB), .FIFO_DEPTH(2), .MSB_FIRST(1'b1),
      .HDR_EN(1'b1), .HDR_BYTE(8'hA5), .CSUM_EN(1'b1), .GUARD(1)
   ) dut_a (
      .clk(clk), .rst_n(rst_n),
      .s_data(sdata[0]), .s_valid(svalid[0]), .s_ready(sready[0]),
      .tx_busy(busy[0]), .tx_data(txd[0]), .tx_send(txs[0]),
      .frame_done(fd[0]), .active(act[0])
   );

   frame_uart_serializer #(
      .N_BYTES(NB), .FIFO_DEPTH(2), .MSB_FIRST(1'b0),
      .HDR_EN(1'b1), .HDR_BYTE(8'hA5), .CSUM_EN(1'b0), .GUARD(1)
   ) dut_b (
      .clk(clk), .rst_n(rst_n),
      .s_data(sdata[1]), .s_valid(svalid[1]), .s_ready(sready[1]),
      .tx_busy(busy[1]), .tx_data(txd[1]), .tx_send(txs[1]),
      .frame_done(fd[1]), .active(act[1])
   );

   // UART model: busy for 10 cycles after each strobe.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int k = 0; k < 2; k++) begin
         if (txs[k] === 1'b1) bc[k] <= 10;
         else if (bc[k] > 0) bc[k] <= bc[k] - 1;
      end
   end

   assign busy[0] = (bc[0] != 0) || hold[0];
   assign busy[1] = (bc[1] != 0) || hold[1];

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (fd[k] === 1'b1 && txs[k] !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL done_without_send dut%0d", k);
         end
         if (txs[k] === 1'b1) begin
            total++;
            if (busy[k] !== 1'b0) begin
               bad++;
               $display("FAIL busy_at_send dut%0d actual=%b required=0",
                        k, busy[k]);
            end
            total++;
            if (cyc - last[k] < 2) begin
               bad++;
               $display("FAIL strobe_spacing dut%0d actual=%0d required>=2",
                        k, cyc - last[k]);
            end
            last[k] = cyc;
            if (nstr[k] < 64) begin
               cap[k][nstr[k]]  = txd[k];
               capd[k][nstr[k]] = fd[k];
            end
            nstr[k]++;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] a,
                      input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, a, e);
      end
   endtask

   task automatic push(input int k, input logic [31:0] d);
      int n = 0;
      sdata[k]  = d;
      svalid[k] = 1'b1;
      while (sready[k] !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) begin
         total++;
         bad++;
         $display("FAIL push_timeout dut%0d", k);
      end
      @(posedge clk);
      @(negedge clk);
      svalid[k] = 1'b0;
   endtask

   task automatic wait_n(input int k, input int target, input int budget);
      int n = 0;
      while (nstr[k] < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("strobes_reached_dut%0d", k),
          32'(nstr[k] >= target), 32'd1);
   endtask

   task automatic wait_idle(input int k);
      int n = 0;
      while (act[k] !== 1'b0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("idle_reached_dut%0d", k), 32'(act[k]), 32'd0);
      repeat (12) @(negedge clk);
   endtask

   task automatic check_frame(input int v, input int base, input bit full);
      int k = vec[v].k;
      logic [7:0] e;
      for (int i = 0; i < vec[v].n; i++) begin
         e = vec[v].exp[47 - 8*i -: 8];
         chk($sformatf("v%0d_byte%0d", v, i),
             32'(cap[k][base + i]), 32'(e));
         chk($sformatf("v%0d_done%0d", v, i),
             32'(capd[k][base + i]),
             32'(full && (i == vec[v].n - 1)));
      end
   endtask

   task automatic check_reset(input int k);
      chk($sformatf("rst_send_dut%0d", k), 32'(txs[k]), 32'd0);
      chk($sformatf("rst_data_dut%0d", k), 32'(txd[k]), 32'd0);
      chk($sformatf("rst_done_dut%0d", k), 32'(fd[k]), 32'd0);
      chk($sformatf("rst_active_dut%0d", k), 32'(act[k]), 32'd0);
      chk($sformatf("rst_ready_dut%0d", k), 32'(sready[k]), 32'd1);
   endtask

   initial begin
      int base;
      int c;
      int k;

      vec[0] = '{0, 32'h11223344, 6, 48'hA5_11_22_33_44_AA};
      vec[1] = '{1, 32'h11223344, 5, 48'hA5_44_33_22_11_00};
      vec[2] = '{0, 32'h01020304, 6, 48'hA5_01_02_03_04_0A};
      vec[3] = '{0, 32'hDEADBEEF, 6, 48'hA5_DE_AD_BE_EF_38};
      vec[4] = '{0, 32'h80808080, 6, 48'hA5_80_80_80_80_00};
      vec[5] = '{0, 32'hFFFFFFFF, 6, 48'hA5_FF_FF_FF_FF_FC};
      vec[6] = '{0, 32'h55667788, 2, 48'hA5_55_00_00_00_00};

      for (int i = 0; i < 2; i++) begin
         sdata[i]  = '0;
         svalid[i] = 1'b0;
         hold[i]   = 1'b0;
      end

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_reset(0);
      check_reset(1);

      // Single frames on both configurations.
      for (int v = 0; v < 2; v++) begin
         k    = vec[v].k;
         base = nstr[k];
         push(k, vec[v].frame);
         sdata[k] = 32'h5A5A5A5A;
         chk($sformatf("active_v%0d", v), 32'(act[k]), 32'd1);
         wait_n(k, base + vec[v].n, 600);
         check_frame(v, base, 1'b1);
         wait_idle(k);
         chk($sformatf("strobe_count_v%0d", v),
             32'(nstr[k] - base), 32'(vec[v].n));
      end

      // Three frames back to back into a two-deep FIFO.
      base = nstr[0];
      push(0, vec[2].frame);
      push(0, vec[3].frame);
      push(0, vec[4].frame);
      chk("ready_low_when_full", 32'(sready[0]), 32'd0);
      repeat (20) @(negedge clk);
      chk("ready_low_before_pop", 32'(sready[0]), 32'd0);
      wait_n(0, base + 18, 1500);
      check_frame(2, base, 1'b1);
      check_frame(3, base + 6, 1'b1);
      check_frame(4, base + 12, 1'b1);
      wait_idle(0);
      chk("ready_high_after_drain", 32'(sready[0]), 32'd1);
      chk("strobe_count_b2b", 32'(nstr[0] - base), 32'd18);

      // Checksum wrap and a long busy stall mid-frame.
      base = nstr[0];
      push(0, vec[5].frame);
      wait_n(0, base + 2, 300);
      @(negedge clk);
      hold[0] = 1'b1;
      c = nstr[0];
      repeat (200) @(negedge clk);
      chk("no_send_while_busy", 32'(nstr[0]), 32'(c));
      hold[0] = 1'b0;
      wait_n(0, base + 6, 300);
      check_frame(5, base, 1'b1);
      wait_idle(0);

      // Reset aborts the frame in flight and the queued one.
      base = nstr[0];
      push(0, vec[6].frame);
      push(0, 32'h01010101);
      wait_n(0, base + 2, 300);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset(0);
      rst_n = 1'b1;
      c = nstr[0];
      repeat (150) @(negedge clk);
      chk("no_send_after_reset", 32'(nstr[0]), 32'(c));
      chk("idle_after_reset", 32'(act[0]), 32'd0);
      chk("ready_after_reset", 32'(sready[0]), 32'd1);
      check_frame(6, base, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
